seq_divider: RTL and testbench



---
 rtl/seq_divider_pkg.sv | 17 +
 rtl/seq_divider_if.sv | 38 +++
 rtl/seq_divider_step.sv | 22 ++
 rtl/seq_divider.sv | 134 +++++++++++++
 tb/tb_seq_divider.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Sliced down to WIDTH at the point of use.
  localparam logic [63:0] DBZ_QUOTIENT = '1;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// is_signed exists only when SEQ_DIVIDER_SIGNED_EN is defined.
interface seq_divider_if #(parameter int unsigned WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             is_signed;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

`ifdef SEQ_DIVIDER_SIGNED_EN
  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );
  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
`endif

endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract.
module seq_divider_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             next_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, next_bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_bit_o = ~diff[WIDTH];
    rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider, one restoring step per clock, valid/ready on both sides.
// Signed operands supported when SEQ_DIVIDER_SIGNED_EN is defined.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic a_neg, b_neg;

  assign a_neg = bus.is_signed & bus.dividend[WIDTH-1];
  assign b_neg = bus.is_signed & bus.divisor[WIDTH-1];
  assign a_mag = a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
  assign b_mag = b_neg ? (~bus.divisor + 1'b1) : bus.divisor;
`else
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
`endif

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  seq_divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_i      (rem_q),
    .next_bit_i (quo_q[WIDTH-1]),
    .divisor_i  (dvs_q),
    .rem_o      (step_rem),
    .q_bit_o    (step_q)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      RUN: begin
        // quo_q doubles as the dividend shifter: MSBs feed the step, LSBs collect quotient bits.
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
`ifdef SEQ_DIVIDER_SIGNED_EN
          if (qneg_q) quo_d = ~{quo_q[WIDTH-2:0], step_q} + 1'b1;
          if (rneg_q) rem_d = ~step_rem + 1'b1;
`endif
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      IDLE: ;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      dvs_d = b_mag;
      cnt_d = CW'(WIDTH - 1);
      dbz_d = (bus.divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_d = a_neg ^ b_neg;
      rneg_d = a_neg;
`endif
      if (bus.divisor == '0) begin
        state_d = DONE;
        quo_d   = DBZ_QUOTIENT[WIDTH-1:0];
        rem_d   = bus.dividend;
      end else begin
        state_d = RUN;
        quo_d   = a_mag;
        rem_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed WIDTH=8 checks plus a randomized WIDTH=16 sweep against an arithmetic reference.
module tb_seq_divider;

  localparam int unsigned W8     = 8;
  localparam int unsigned W16    = 16;
  localparam int          N_RND  = 1500;
  localparam int          BUDGET = 70000;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W8))  b8 ();
  seq_divider_if #(.WIDTH(W16)) b16 ();

  seq_divider #(.WIDTH(W8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  seq_divider #(.WIDTH(W16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

  int n_checks = 0;
  int n_errors = 0;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sgn8 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present operands (divider must be ready), take the accepting edge, then scramble inputs.
  task automatic present8(input logic [7:0] a, input logic [7:0] b, input string tag);
    b8.dividend = a;
    b8.divisor  = b;
`ifdef SEQ_DIVIDER_SIGNED_EN
    b8.is_signed = sgn8;
`endif
    b8.in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(b8.in_ready), 1);
    tick;
    b8.in_valid = 1'b0;
    b8.dividend = 8'($urandom);
    b8.divisor  = 8'($urandom);
  endtask

  task automatic wait_valid8(input string tag, input int exp_lat);
    int lat = 1;
    while (!b8.out_valid && lat < 40) begin
      tick;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic res8(input string tag, input logic [7:0] q, input logic [7:0] r, input logic dbz);
    chk({tag, "_quotient"},  32'(b8.quotient),    32'(q));
    chk({tag, "_remainder"}, 32'(b8.remainder),   32'(r));
    chk({tag, "_dbz"},       32'(b8.div_by_zero), 32'(dbz));
  endtask

  task automatic reset_vals8(input string tag);
    chk({tag, "_in_ready"},  32'(b8.in_ready),    1);
    chk({tag, "_out_valid"}, 32'(b8.out_valid),   0);
    chk({tag, "_quotient"},  32'(b8.quotient),    0);
    chk({tag, "_remainder"}, 32'(b8.remainder),   0);
    chk({tag, "_dbz"},       32'(b8.div_by_zero), 0);
  endtask

  function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    int   sa, sb;
    e.acc_cyc = 0;
    if (b == 16'd0) begin
      e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      e.q = 16'(sa / sb); e.r = 16'(sa % sb); e.dbz = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  exp_t q_exp[$];
  exp_t e, cur;
  int   sent, cyc, sel;
  bit   seen, fin, fout, last_fin;
  logic s_cur;

  initial begin
    rst_n = 1'b0;
    b8.in_valid = 1'b0;  b8.dividend = '0;  b8.divisor = '0;  b8.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.dividend = '0; b16.divisor = '0; b16.out_ready = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    b8.is_signed = 1'b0;
    b16.is_signed = 1'b0;
`endif
    repeat (3) tick;
    reset_vals8("rst");
    rst_n = 1'b1;
    tick;
    reset_vals8("idle");

    present8(8'd200, 8'd7, "t1");
    wait_valid8("t1", 9);
    res8("t1", 8'd28, 8'd4, 1'b0);
    chk("t1_in_ready_done", 32'(b8.in_ready), 1);
    tick;
    chk("t1_back_idle", 32'(b8.out_valid), 0);

    present8(8'd55, 8'd0, "t2");
    wait_valid8("t2", 1);
    res8("t2", 8'hFF, 8'd55, 1'b1);
    tick;

    b8.out_ready = 1'b0;
    present8(8'd3, 8'd200, "t3");
    wait_valid8("t3", 9);
    res8("t3", 8'd0, 8'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t3_hold_valid", 32'(b8.out_valid), 1);
      chk("t3_hold_in_ready", 32'(b8.in_ready), 0);
      res8("t3_hold", 8'd0, 8'd3, 1'b0);
    end
    b8.out_ready = 1'b1;
    b8.dividend = 8'd255;
    b8.divisor  = 8'd1;
    b8.in_valid = 1'b1;
    #1;
    chk("t3_in_ready_release", 32'(b8.in_ready), 1);
    tick;
    b8.in_valid = 1'b0;
    chk("t3_b2b_running", 32'(b8.out_valid), 0);
    wait_valid8("t3b", 9);
    res8("t3b", 8'd255, 8'd0, 1'b0);
    tick;

    present8(8'd77, 8'd5, "t4");
    repeat (4) tick;
    rst_n = 1'b0;
    #1;
    reset_vals8("t4_rst_run");
    tick;
    rst_n = 1'b1;
    tick;
    present8(8'd100, 8'd10, "t4b");
    wait_valid8("t4b", 9);
    res8("t4b", 8'd10, 8'd0, 1'b0);
    tick;

    b8.out_ready = 1'b0;
    present8(8'd9, 8'd0, "t5");
    wait_valid8("t5", 1);
    res8("t5", 8'hFF, 8'd9, 1'b1);
    rst_n = 1'b0;
    #1;
    reset_vals8("t5_rst_done");
    tick;
    rst_n = 1'b1;
    b8.out_ready = 1'b1;
    tick;

    present8(8'h80, 8'hFF, "t6");
    wait_valid8("t6", 9);
    res8("t6", 8'h00, 8'h80, 1'b0);
    tick;

`ifdef SEQ_DIVIDER_SIGNED_EN
    sgn8 = 1'b1;
    present8(8'h9C, 8'h07, "s1");
    wait_valid8("s1", 9);
    res8("s1", 8'hF2, 8'hFE, 1'b0);
    tick;
    present8(8'h80, 8'hFF, "s2");
    wait_valid8("s2", 9);
    res8("s2", 8'h80, 8'h00, 1'b0);
    tick;
    present8(8'h64, 8'hF9, "s3");
    wait_valid8("s3", 9);
    res8("s3", 8'hF2, 8'h02, 1'b0);
    tick;
    present8(8'hFB, 8'h00, "s4");
    wait_valid8("s4", 1);
    res8("s4", 8'hFF, 8'hFB, 1'b1);
    tick;
    sgn8 = 1'b0;
    present8(8'h9C, 8'h07, "s5");
    wait_valid8("s5", 9);
    res8("s5", 8'h16, 8'h02, 1'b0);
    tick;
`endif

    sent = 0; cyc = 0; seen = 1'b0; last_fin = 1'b0; s_cur = 1'b0;
    while ((sent < N_RND || q_exp.size() > 0) && cyc < BUDGET) begin
      tick;
      cyc++;
      if (last_fin) b16.in_valid = 1'b0;
      b16.out_ready = ($urandom_range(3) != 0);
      if (!b16.in_valid && sent < N_RND && $urandom_range(2) != 0) begin
        sel = int'($urandom_range(7));
        b16.dividend = 16'($urandom);
        case (sel)
          0:       b16.divisor = 16'd0;
          1:       b16.divisor = 16'($urandom_range(15, 1));
          2: begin b16.dividend = 16'h8000; b16.divisor = 16'hFFFF; end
          default: b16.divisor = 16'($urandom);
        endcase
`ifdef SEQ_DIVIDER_SIGNED_EN
        s_cur = 1'($urandom_range(1));
        b16.is_signed = s_cur;
`endif
        b16.in_valid = 1'b1;
      end
      #1;
      if (b16.out_valid && !seen) begin
        seen = 1'b1;
        if (q_exp.size() > 0)
          chk("rnd_latency", cyc - q_exp[0].acc_cyc, q_exp[0].dbz ? 1 : W16 + 1);
        else
          chk("rnd_spurious_valid", 32'(b16.out_valid), 0);
      end
      fout = b16.out_valid && b16.out_ready;
      fin  = b16.in_valid && b16.in_ready;
      if (fout) begin
        seen = 1'b0;
        if (q_exp.size() > 0) begin
          cur = q_exp.pop_front();
          chk("rnd_quotient",  32'(b16.quotient),    32'(cur.q));
          chk("rnd_remainder", 32'(b16.remainder),   32'(cur.r));
          chk("rnd_dbz",       32'(b16.div_by_zero), 32'(cur.dbz));
        end else begin
          chk("rnd_unexpected_result", 32'(b16.out_valid), 0);
        end
      end
      if (fin) begin
        e = model16(b16.dividend, b16.divisor, s_cur);
        e.acc_cyc = cyc;
        q_exp.push_back(e);
        sent++;
      end
      last_fin = fin;
    end
    chk("rnd_outstanding_work", 32'(q_exp.size() + (N_RND - sent)), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
